// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the Mach-V core: resolves branches and jumps from the ALU flags,
// issues a one-cycle fetch redirect, kills the wrong-path instruction behind it, counts branches.
module ex_mem_stage (
    input  logic        CLK,
    input  logic        RESETN,

    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ALUResult,
    input  logic [2:0]  ALUFlags,
    input  logic [31:0] PC,
    input  logic [31:0] Imm,
    input  logic        IsBranch,
    input  logic        IsJal,
    input  logic        IsJalr,
    input  logic [2:0]  Funct3,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [4:0]  Rd,
    input  logic [31:0] WriteData,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_result,
    output logic        mem_RegWrite,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [4:0]  mem_Rd,
    output logic [31:0] mem_WriteData,
    output logic        mem_excp,

    output logic        Redirect,
    output logic [31:0] RedirectPC,

    output logic [31:0] BrCount,
    output logic [31:0] TakenCount
);

    logic        mem_valid_q,     mem_valid_d;
    logic [31:0] mem_result_q,    mem_result_d;
    logic        mem_regwrite_q,  mem_regwrite_d;
    logic        mem_memread_q,   mem_memread_d;
    logic        mem_memwrite_q,  mem_memwrite_d;
    logic [4:0]  mem_rd_q,        mem_rd_d;
    logic [31:0] mem_wdata_q,     mem_wdata_d;
    logic        mem_excp_q,      mem_excp_d;
    logic        redirect_q,      redirect_d;
    logic [31:0] redirect_pc_q,   redirect_pc_d;
    logic [31:0] br_count_q,      br_count_d;
    logic [31:0] taken_count_q,   taken_count_d;

    logic        flag_eq;
    logic        flag_lt;
    logic        flag_ltu;
    logic        br_cond;
    logic        is_link;
    logic        taken;
    logic        misaligned;
    logic        accept;
    logic        live;
    logic [31:0] target;
    logic [31:0] link_pc;

    assign {flag_eq, flag_lt, flag_ltu} = ALUFlags;

    always_comb begin
        br_cond = 1'b0;
        case (Funct3)
            3'b000:  br_cond = flag_eq;
            3'b001:  br_cond = ~flag_eq;
            3'b100:  br_cond = flag_lt;
            3'b101:  br_cond = ~flag_lt;
            3'b110:  br_cond = flag_ltu;
            3'b111:  br_cond = ~flag_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    assign is_link    = IsJal | IsJalr;
    assign taken      = (IsBranch & br_cond) | is_link;
    assign target     = IsJalr ? {ALUResult[31:1], 1'b0} : (PC + Imm);
    assign misaligned = taken & (target[1:0] != 2'b00);
    assign link_pc    = PC + 32'd4;

    // While a redirect is out, the presented instruction is wrong-path: always take it and drop it.
    assign ex_ready = redirect_q | ~mem_valid_q | mem_ready;
    assign accept   = ex_valid & ex_ready;
    assign live     = accept & ~redirect_q;

    always_comb begin
        mem_valid_d    = mem_valid_q;
        mem_result_d   = mem_result_q;
        mem_regwrite_d = mem_regwrite_q;
        mem_memread_d  = mem_memread_q;
        mem_memwrite_d = mem_memwrite_q;
        mem_rd_d       = mem_rd_q;
        mem_wdata_d    = mem_wdata_q;
        mem_excp_d     = mem_excp_q;
        redirect_d     = 1'b0;
        redirect_pc_d  = redirect_pc_q;
        br_count_d     = br_count_q;
        taken_count_d  = taken_count_q;

        if (live) begin
            mem_valid_d    = 1'b1;
            mem_result_d   = is_link ? link_pc : ALUResult;
            mem_regwrite_d = RegWrite & ~misaligned;
            mem_memread_d  = MemRead;
            mem_memwrite_d = MemWrite;
            mem_rd_d       = Rd;
            mem_wdata_d    = WriteData;
            mem_excp_d     = misaligned;

            if (taken & ~misaligned) begin
                redirect_d    = 1'b1;
                redirect_pc_d = target;
            end

            if (IsBranch) begin
                br_count_d = br_count_q + 32'd1;
                if (br_cond) begin
                    taken_count_d = taken_count_q + 32'd1;
                end
            end
        end else if (mem_valid_q & mem_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            mem_valid_q    <= 1'b0;
            mem_result_q   <= 32'd0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_rd_q       <= 5'd0;
            mem_wdata_q    <= 32'd0;
            mem_excp_q     <= 1'b0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= 32'd0;
            br_count_q     <= 32'd0;
            taken_count_q  <= 32'd0;
        end else begin
            mem_valid_q    <= mem_valid_d;
            mem_result_q   <= mem_result_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memread_q  <= mem_memread_d;
            mem_memwrite_q <= mem_memwrite_d;
            mem_rd_q       <= mem_rd_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_excp_q     <= mem_excp_d;
            redirect_q     <= redirect_d;
            redirect_pc_q  <= redirect_pc_d;
            br_count_q     <= br_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign mem_valid     = mem_valid_q;
    assign mem_result    = mem_result_q;
    assign mem_RegWrite  = mem_regwrite_q;
    assign mem_MemRead   = mem_memread_q;
    assign mem_MemWrite  = mem_memwrite_q;
    assign mem_Rd        = mem_rd_q;
    assign mem_WriteData = mem_wdata_q;
    assign mem_excp      = mem_excp_q;
    assign Redirect      = redirect_q;
    assign RedirectPC    = redirect_pc_q;
    assign BrCount       = br_count_q;
    assign TakenCount    = taken_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, hand-written multi-cycle sequences,
// then random traffic scored against an operand-level reference model.
module tb_ex_mem_stage;

    logic        CLK;
    logic        RESETN;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ALUResult;
    logic [2:0]  ALUFlags;
    logic [31:0] PC;
    logic [31:0] Imm;
    logic        IsBranch;
    logic        IsJal;
    logic        IsJalr;
    logic [2:0]  Funct3;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic [4:0]  Rd;
    logic [31:0] WriteData;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_result;
    logic        mem_RegWrite;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [4:0]  mem_Rd;
    logic [31:0] mem_WriteData;
    logic        mem_excp;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] BrCount;
    logic [31:0] TakenCount;

    ex_mem_stage dut (
        .CLK(CLK), .RESETN(RESETN),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags), .PC(PC), .Imm(Imm),
        .IsBranch(IsBranch), .IsJal(IsJal), .IsJalr(IsJalr), .Funct3(Funct3),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Rd(Rd), .WriteData(WriteData),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
        .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_Rd(mem_Rd), .mem_WriteData(mem_WriteData), .mem_excp(mem_excp),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .BrCount(BrCount), .TakenCount(TakenCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        ex_valid  = 1'b0;
        IsBranch  = 1'b0;
        IsJal     = 1'b0;
        IsJalr    = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                         input logic [2:0] fl, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] alu, input logic rw);
        ex_valid  = 1'b1;
        IsBranch  = b;
        IsJal     = j;
        IsJalr    = jr;
        Funct3    = f3;
        ALUFlags  = fl;
        PC        = pc;
        Imm       = imm;
        ALUResult = alu;
        RegWrite  = rw;
    endtask

    typedef struct packed {
        logic        isb;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [2:0]  flags;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        rw;
        logic [31:0] e_res;
        logic        e_excp;
        logic        e_rw;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_dbr;
        logic        e_dtk;
    } vec_t;

    vec_t        vt [15];
    logic [31:0] exp_br;
    logic [31:0] exp_tk;

    // Reference model state: one MEM slot, the pending redirect and the counters.
    logic        m_valid, m_rw, m_mr, m_mw, m_excp, m_redir;
    logic [31:0] m_result, m_wd, m_rpc, m_br, m_tk;
    logic [4:0]  m_rd;
    logic [31:0] op_a, op_b;

    function automatic bit branch_true(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit          was_redir, acc, cond, tk, mis;
        logic [31:0] tgt;
        was_redir = m_redir;
        acc       = ex_valid && (m_redir || !m_valid || mem_ready);
        m_redir   = 1'b0;
        if (acc && !was_redir) begin
            cond = IsBranch && branch_true(Funct3, op_a, op_b);
            tk   = cond || IsJal || IsJalr;
            tgt  = IsJalr ? (ALUResult & 32'hFFFF_FFFE) : (PC + Imm);
            mis  = tk && (tgt % 4 != 0);
            m_valid  = 1'b1;
            m_result = (IsJal || IsJalr) ? PC + 32'd4 : ALUResult;
            m_rw     = RegWrite && !mis;
            m_mr     = MemRead;
            m_mw     = MemWrite;
            m_rd     = Rd;
            m_wd     = WriteData;
            m_excp   = mis;
            if (tk && !mis) begin
                m_redir = 1'b1;
                m_rpc   = tgt;
            end
            if (IsBranch) m_br = m_br + 32'd1;
            if (cond)     m_tk = m_tk + 32'd1;
        end else if (m_valid && mem_ready) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        //                isb   jal   jalr  f3      flags   pc             imm            alu            rw    e_res          excp  e_rw  redir e_rpc          dbr   dtk
        vt[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 32'h0000_0100, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0120, 1'b1, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 3'b110, 3'b000, 32'h0000_0200, 32'h0000_0040, 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 32'h0000_0300, 32'hFFFF_FFF0, 32'h0000_0007, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 32'h0000_02F0, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0040, 32'h0000_0000, 32'h0000_2003, 1'b1, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_1000, 32'h0000_0800, 32'h0000_0000, 1'b1, 32'h0000_1004, 1'b0, 1'b1, 1'b1, 32'h0000_1800, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_1000, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0050, 32'h0000_0000, 32'h0000_3001, 1'b1, 32'h0000_0054, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 3'b010, 3'b111, 32'h0000_0400, 32'h0000_0010, 32'h0000_0009, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 32'h0000_0100, 32'h0000_0002, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0000_0500, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 3'b100, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1};
        vt[11] = '{1'b1, 1'b0, 1'b0, 3'b111, 3'b001, 32'h0000_0600, 32'h0000_0020, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b011, 32'h0000_0700, 32'h0000_0020, 32'h0000_0002, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b010, 32'h0000_0800, 32'h0000_0040, 32'h0000_0003, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

        RESETN = 1'b0;
        ALUResult = '0; ALUFlags = '0; PC = '0; Imm = '0; Funct3 = '0; Rd = '0; WriteData = '0;
        idle(0);
        #1;
        chk1 ("reset_mem_valid", mem_valid, 1'b0);
        chk1 ("reset_redirect", Redirect, 1'b0);
        chk32("reset_redirect_pc", RedirectPC, 32'h0);
        chk32("reset_mem_result", mem_result, 32'h0);
        chk32("reset_ctrl", {27'd0, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_excp, 1'b0}, 32'h0);
        chk32("reset_rd_wd", {27'd0, mem_Rd} | mem_WriteData, 32'h0);
        chk32("reset_brcount", BrCount, 32'h0);
        chk32("reset_takencount", TakenCount, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        cyc();
        chk1("idle_ex_ready", ex_ready, 1'b1);
        exp_br = '0;
        exp_tk = '0;

        for (int i = 0; i < 15; i++) begin
            idle(2);
            drive(vt[i].isb, vt[i].jal, vt[i].jalr, vt[i].f3, vt[i].flags,
                  vt[i].pc, vt[i].imm, vt[i].alu, vt[i].rw);
            Rd        = 5'(i + 1);
            WriteData = 32'h1000 + 32'(i);
            MemRead   = 1'b1;
            cyc();
            exp_br = exp_br + 32'(vt[i].e_dbr);
            exp_tk = exp_tk + 32'(vt[i].e_dtk);
            chk1 ($sformatf("vec%0d_mem_valid", i), mem_valid, 1'b1);
            chk32($sformatf("vec%0d_mem_result", i), mem_result, vt[i].e_res);
            chk1 ($sformatf("vec%0d_mem_excp", i), mem_excp, vt[i].e_excp);
            chk1 ($sformatf("vec%0d_mem_regwrite", i), mem_RegWrite, vt[i].e_rw);
            chk1 ($sformatf("vec%0d_mem_memread", i), mem_MemRead, 1'b1);
            chk32($sformatf("vec%0d_rd_wd", i), {27'd0, mem_Rd} ^ mem_WriteData, 32'(i + 1) ^ (32'h1000 + 32'(i)));
            chk1 ($sformatf("vec%0d_redirect", i), Redirect, vt[i].e_redir);
            if (vt[i].e_redir) chk32($sformatf("vec%0d_redirect_pc", i), RedirectPC, vt[i].e_rpc);
            chk32($sformatf("vec%0d_brcount", i), BrCount, exp_br);
            chk32($sformatf("vec%0d_takencount", i), TakenCount, exp_tk);
            idle(1);
            chk1($sformatf("vec%0d_redirect_one_cycle", i), Redirect, 1'b0);
        end

        // Taken BEQ, then a taken branch during the redirect cycle must be dropped.
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 32'h100, 32'h20, 32'h0, 1'b0);
        cyc();
        exp_br = exp_br + 32'd1;
        exp_tk = exp_tk + 32'd1;
        chk1 ("kill_redirect", Redirect, 1'b1);
        chk32("kill_redirect_pc", RedirectPC, 32'h120);
        chk1 ("kill_first_valid", mem_valid, 1'b1);
        chk32("kill_first_brcount", BrCount, exp_br);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 32'h104, 32'h40, 32'h0, 1'b1);
        #1;
        chk1("kill_ex_ready", ex_ready, 1'b1);
        cyc();
        chk1 ("kill_mem_valid", mem_valid, 1'b0);
        chk1 ("kill_no_redirect", Redirect, 1'b0);
        chk32("kill_brcount", BrCount, exp_br);
        chk32("kill_takencount", TakenCount, exp_tk);

        // MEM stall for three cycles with a new instruction waiting.
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 32'h800, 32'h0, 32'hA1, 1'b1);
        cyc();
        mem_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 32'h804, 32'h0, 32'hB2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1($sformatf("stall%0d_ex_ready", k), ex_ready, 1'b0);
            cyc();
            chk32($sformatf("stall%0d_mem_result", k), mem_result, 32'hA1);
            chk1 ($sformatf("stall%0d_mem_valid", k), mem_valid, 1'b1);
        end
        mem_ready = 1'b1;
        #1;
        chk1("stall_release_ex_ready", ex_ready, 1'b1);
        cyc();
        chk32("stall_release_result", mem_result, 32'hB2);
        chk1 ("stall_release_valid", mem_valid, 1'b1);
        ex_valid = 1'b0;
        cyc();
        chk1("drain_only_valid", mem_valid, 1'b0);

        // Redirect cycle while MEM is stalled: killed input must not disturb the held JAL.
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 32'h2000, 32'h10, 32'h0, 1'b1);
        cyc();
        chk1 ("rstall_redirect", Redirect, 1'b1);
        chk32("rstall_redirect_pc", RedirectPC, 32'h2010);
        mem_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 32'h2004, 32'h0, 32'hC3, 1'b1);
        #1;
        chk1("rstall_ex_ready", ex_ready, 1'b1);
        cyc();
        chk1 ("rstall_redirect_drop", Redirect, 1'b0);
        chk1 ("rstall_held_valid", mem_valid, 1'b1);
        chk32("rstall_held_result", mem_result, 32'h2004);
        chk1 ("rstall_held_regwrite", mem_RegWrite, 1'b1);
        idle(1);
        chk1("rstall_drain", mem_valid, 1'b0);

        // Counter wrap from 0xFFFFFFFF.
        idle(2);
        force dut.br_count_q = 32'hFFFF_FFFF;
        force dut.taken_count_q = 32'hFFFF_FFFF;
        cyc();
        release dut.br_count_q;
        release dut.taken_count_q;
        #1;
        chk32("wrap_preload_br", BrCount, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 32'h100, 32'h20, 32'h0, 1'b0);
        cyc();
        chk32("wrap_brcount", BrCount, 32'h0);
        chk32("wrap_takencount", TakenCount, 32'h0);
        idle(2);

        // Asynchronous reset while a redirect is pending.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b100, 32'h300, 32'h40, 32'h0, 1'b1);
        cyc();
        chk1("arst_pre_redirect", Redirect, 1'b1);
        ex_valid = 1'b0;
        #2;
        RESETN = 1'b0;
        #1;
        chk1 ("arst_redirect", Redirect, 1'b0);
        chk32("arst_redirect_pc", RedirectPC, 32'h0);
        chk1 ("arst_mem_valid", mem_valid, 1'b0);
        chk32("arst_mem_result", mem_result, 32'h0);
        chk32("arst_brcount", BrCount, 32'h0);
        chk32("arst_takencount", TakenCount, 32'h0);
        idle(1);
        @(negedge CLK);
        RESETN = 1'b1;
        cyc();
        chk1("arst_no_pulse", Redirect, 1'b0);
        chk1("arst_no_valid", mem_valid, 1'b0);
        cyc();
        chk1("arst_no_pulse_late", Redirect, 1'b0);

        // Random traffic against the reference model.
        m_valid = 1'b0; m_redir = 1'b0; m_excp = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        m_result = '0; m_wd = '0; m_rpc = '0; m_rd = '0; m_br = '0; m_tk = '0;
        for (int c = 0; c < 3000; c++) begin
            int cls;
            cls  = int'($urandom_range(0, 5));
            op_a = $urandom;
            if ($urandom_range(0, 3) == 0) op_b = op_a;
            else if ($urandom_range(0, 1) == 0) op_b = op_a ^ 32'h8000_0000;
            else op_b = $urandom;
            ex_valid  = ($urandom_range(0, 4) != 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            IsBranch  = (cls <= 2);
            IsJal     = (cls == 3);
            IsJalr    = (cls == 4);
            Funct3    = 3'($urandom_range(0, 7));
            ALUFlags  = {op_a == op_b, $signed(op_a) < $signed(op_b), op_a < op_b};
            PC        = $urandom & 32'hFFFF_FFFC;
            Imm       = 32'($urandom_range(0, 4095)) - 32'd2048;
            if ($urandom_range(0, 3) != 0) Imm = Imm & 32'hFFFF_FFFC;
            ALUResult = IsBranch ? op_a - op_b : $urandom;
            if (IsJalr && $urandom_range(0, 1) == 0) ALUResult = ALUResult & 32'hFFFF_FFFC;
            RegWrite  = 1'($urandom_range(0, 1));
            MemRead   = 1'($urandom_range(0, 1));
            MemWrite  = 1'($urandom_range(0, 1));
            Rd        = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            #1;
            chk1("rnd_ex_ready", ex_ready, m_redir || !m_valid || mem_ready);
            model_step();
            cyc();
            chk1 ("rnd_mem_valid", mem_valid, m_valid);
            chk1 ("rnd_redirect", Redirect, m_redir);
            chk32("rnd_brcount", BrCount, m_br);
            chk32("rnd_takencount", TakenCount, m_tk);
            if (m_redir) chk32("rnd_redirect_pc", RedirectPC, m_rpc);
            if (m_valid) begin
                chk32("rnd_mem_result", mem_result, m_result);
                chk32("rnd_mem_ctrl", {28'd0, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_excp},
                      {28'd0, m_rw, m_mr, m_mw, m_excp});
                chk32("rnd_mem_rd", 32'(mem_Rd), 32'(m_rd));
                chk32("rnd_mem_wdata", mem_WriteData, m_wd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
